// File: rtl/if_stage_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package if_stage_pkg;
  localparam int          XLEN      = 32;
  localparam int          IMEM_AW   = 6;
  localparam logic [31:0] RESET_PC  = 32'h0000_0008;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: hold beats bubble, bubble beats load.
module if_id_reg #(
  parameter int          XLEN      = if_stage_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            bubble,
  input  logic            hold,
  input  logic [XLEN-1:0] d_pc,
  input  logic [XLEN-1:0] d_pc4,
  input  logic [31:0]     d_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic [31:0]     instr
);
  logic            valid_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc4_reg;
  logic [31:0]     instr_reg;

  // A bubble leaves pc/pc4 untouched; consumers qualify with valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      pc4_reg   <= XLEN'(4);
      instr_reg <= NOP_INSTR;
    end else if (hold) begin
      valid_reg <= valid_reg;
    end else if (bubble) begin
      valid_reg <= 1'b0;
      instr_reg <= NOP_INSTR;
    end else if (load) begin
      valid_reg <= 1'b1;
      pc_reg    <= d_pc;
      pc4_reg   <= d_pc4;
      instr_reg <= d_instr;
    end
  end

  assign valid = valid_reg;
  assign pc    = pc_reg;
  assign pc4   = pc4_reg;
  assign instr = instr_reg;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the BOOT/RUN/HALT FSM and the fetch counter.
module if_stage #(
  parameter int          XLEN      = if_stage_pkg::XLEN,
  parameter int          IMEM_AW   = if_stage_pkg::IMEM_AW,
  parameter logic [31:0] RESET_PC  = if_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_data_i,
  input  logic               stall_i,
  input  logic               mem_conflict_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  input  logic               halt_i,
  output logic [XLEN-1:0]    pc_o,
  output logic               ifid_valid_o,
  output logic [XLEN-1:0]    ifid_pc_o,
  output logic [XLEN-1:0]    ifid_pc4_o,
  output logic [31:0]        ifid_instr_o,
  output logic               halted_o,
  output logic [31:0]        fetch_cnt_o
);
  import if_stage_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_e    state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_plus4;
  logic [31:0]     fetch_cnt_reg;
  logic            halted_reg;
  logic            ifid_load;
  logic            ifid_bubble;
  logic            ifid_hold;
  logic            unused_redirect_lsbs;

  assign pc_plus4             = pc_reg + PC_STEP;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Per-edge action, priority halt > redirect > stall > conflict > fetch.
  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_hold   = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (halt_i || redirect_i) ifid_bubble = 1'b1;
        else if (stall_i)         ifid_hold   = 1'b1;
        else if (mem_conflict_i)  ifid_bubble = 1'b1;
        else                      ifid_load   = 1'b1;
      end
      ST_HALT: ifid_bubble = 1'b1;
      default: ifid_hold   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_BOOT;
      pc_reg        <= RESET_PC[XLEN-1:0];
      fetch_cnt_reg <= '0;
      halted_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_BOOT: state_reg <= ST_RUN;
        ST_RUN: begin
          if (halt_i) begin
            state_reg  <= ST_HALT;
            halted_reg <= 1'b1;
          end else if (redirect_i) begin
            pc_reg <= {redirect_pc_i[XLEN-1:2], 2'b00};
          end else if (ifid_load) begin
            pc_reg        <= pc_plus4;
            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
          end
        end
        ST_HALT: halted_reg <= 1'b1;
        default: state_reg <= ST_BOOT;
      endcase
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ifid_load),
    .bubble  (ifid_bubble),
    .hold    (ifid_hold),
    .d_pc    (pc_reg),
    .d_pc4   (pc_plus4),
    .d_instr (imem_data_i),
    .valid   (ifid_valid_o),
    .pc      (ifid_pc_o),
    .pc4     (ifid_pc4_o),
    .instr   (ifid_instr_o)
  );

  assign imem_addr_o = pc_reg[IMEM_AW+1:2];
  assign pc_o        = pc_reg;
  assign halted_o    = halted_reg;
  assign fetch_cnt_o = fetch_cnt_reg;
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage with a behavioural instruction memory and fetch scoreboard.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  imem_addr_o;
  logic [31:0] imem_data_i;
  logic        stall_i, mem_conflict_i, redirect_i, halt_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, fetch_cnt_o;
  logic        ifid_valid_o, halted_o;

  logic [31:0] mem [64];
  assign imem_data_i = mem[imem_addr_o];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;
  fetch_t sb_q[$];
  fetch_t exp_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr_o    (imem_addr_o),
    .imem_data_i    (imem_data_i),
    .stall_i        (stall_i),
    .mem_conflict_i (mem_conflict_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .halt_i         (halt_i),
    .pc_o           (pc_o),
    .ifid_valid_o   (ifid_valid_o),
    .ifid_pc_o      (ifid_pc_o),
    .ifid_pc4_o     (ifid_pc4_o),
    .ifid_instr_o   (ifid_instr_o),
    .halted_o       (halted_o),
    .fetch_cnt_o    (fetch_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 0; mem_conflict_i = 0; redirect_i = 0; halt_i = 0;
    redirect_pc_i = '0;
    #12;
    checks++;
    if (pc_o !== 32'h8 || imem_addr_o !== 6'd2) begin
      errors++; $display("FAIL reset_pc: got pc=%h addr=%0d expected pc=00000008 addr=2", pc_o, imem_addr_o);
    end
    checks++;
    if (ifid_valid_o !== 1'b0 || ifid_pc_o !== 32'h0 || ifid_pc4_o !== 32'h4 || ifid_instr_o !== 32'h13) begin
      errors++; $display("FAIL reset_ifid: got v=%b pc=%h pc4=%h instr=%h expected v=0 pc=0 pc4=4 instr=00000013",
                         ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o);
    end
    checks++;
    if (halted_o !== 1'b0 || fetch_cnt_o !== 32'd0) begin
      errors++; $display("FAIL reset_misc: got halted=%b cnt=%0d expected halted=0 cnt=0", halted_o, fetch_cnt_o);
    end
    $display("reset: pc=%h ifid_valid=%b cnt=%0d", pc_o, ifid_valid_o, fetch_cnt_o);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_boot_fetch();
    sb_q.push_back('{pc: 32'h8, instr: 32'h0002a083});
    tick();
    checks++;
    if (ifid_valid_o !== 1'b0 || pc_o !== 32'h8) begin
      errors++; $display("FAIL boot_cycle: got v=%b pc=%h expected v=0 pc=00000008", ifid_valid_o, pc_o);
    end
    $display("boot: pc=%h ifid_valid=%b", pc_o, ifid_valid_o);
    tick();
    exp_f = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    checks++;
    if (ifid_valid_o !== 1'b1 || ifid_pc_o !== exp_f.pc || ifid_instr_o !== exp_f.instr ||
        ifid_pc4_o !== exp_f.pc + 32'd4 || pc_o !== 32'hC) begin
      errors++; $display("FAIL first_fetch: got v=%b pc=%h instr=%h pc4=%h pc_o=%h expected v=1 pc=%h instr=%h pc_o=0000000c",
                         ifid_valid_o, ifid_pc_o, ifid_instr_o, ifid_pc4_o, pc_o, exp_f.pc, exp_f.instr);
    end
    $display("fetch: ifid_pc=%h instr=%h", ifid_pc_o, ifid_instr_o);
    sb_q.push_back('{pc: 32'hC, instr: 32'h0042a103});
    tick();
    exp_f = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    checks++;
    if (ifid_valid_o !== 1'b1 || ifid_pc_o !== exp_f.pc || ifid_instr_o !== exp_f.instr || fetch_cnt_o !== 32'd2) begin
      errors++; $display("FAIL second_fetch: got pc=%h instr=%h cnt=%0d expected pc=%h instr=%h cnt=2",
                         ifid_pc_o, ifid_instr_o, fetch_cnt_o, exp_f.pc, exp_f.instr);
    end
    $display("fetch: ifid_pc=%h instr=%h cnt=%0d", ifid_pc_o, ifid_instr_o, fetch_cnt_o);
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc_o !== 32'h10 || ifid_pc_o !== 32'hC || ifid_instr_o !== 32'h0042a103 ||
          ifid_valid_o !== 1'b1 || fetch_cnt_o !== 32'd2) begin
        errors++; $display("FAIL stall_hold[%0d]: got pc=%h ifid_pc=%h instr=%h v=%b cnt=%0d expected pc=10 ifid_pc=c instr=0042a103 v=1 cnt=2",
                           i, pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, fetch_cnt_o);
      end
      $display("stall: pc=%h ifid_pc=%h cnt=%0d", pc_o, ifid_pc_o, fetch_cnt_o);
    end
    stall_i = 1'b0;
    sb_q.push_back('{pc: 32'h10, instr: mem[4]});
    tick();
    exp_f = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    checks++;
    if (ifid_valid_o !== 1'b1 || ifid_pc_o !== exp_f.pc || ifid_instr_o !== exp_f.instr || pc_o !== 32'h14) begin
      errors++; $display("FAIL stall_resume: got pc=%h instr=%h pc_o=%h expected pc=%h instr=%h pc_o=14",
                         ifid_pc_o, ifid_instr_o, pc_o, exp_f.pc, exp_f.instr);
    end
    $display("resume: ifid_pc=%h instr=%h", ifid_pc_o, ifid_instr_o);
  endtask

  task automatic test_conflict();
    mem_conflict_i = 1'b1;
    tick();
    mem_conflict_i = 1'b0;
    checks++;
    if (ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h13 || pc_o !== 32'h14 ||
        ifid_pc_o !== 32'h10 || fetch_cnt_o !== 32'd3) begin
      errors++; $display("FAIL conflict_bubble: got v=%b instr=%h pc=%h ifid_pc=%h cnt=%0d expected v=0 instr=13 pc=14 ifid_pc=10 cnt=3",
                         ifid_valid_o, ifid_instr_o, pc_o, ifid_pc_o, fetch_cnt_o);
    end
    $display("conflict: v=%b pc=%h", ifid_valid_o, pc_o);
    sb_q.push_back('{pc: 32'h14, instr: mem[5]});
    tick();
    exp_f = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    checks++;
    if (ifid_valid_o !== 1'b1 || ifid_pc_o !== exp_f.pc || ifid_instr_o !== exp_f.instr || fetch_cnt_o !== 32'd4) begin
      errors++; $display("FAIL conflict_refetch: got pc=%h instr=%h cnt=%0d expected pc=%h instr=%h cnt=4",
                         ifid_pc_o, ifid_instr_o, fetch_cnt_o, exp_f.pc, exp_f.instr);
    end
    $display("refetch: ifid_pc=%h instr=%h", ifid_pc_o, ifid_instr_o);
  endtask

  task automatic test_redirect();
    redirect_i = 1'b1; redirect_pc_i = 32'h87; stall_i = 1'b1; mem_conflict_i = 1'b1;
    tick();
    redirect_i = 1'b0; stall_i = 1'b0; mem_conflict_i = 1'b0;
    checks++;
    if (pc_o !== 32'h84 || imem_addr_o !== 6'd33 || ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h13 ||
        fetch_cnt_o !== 32'd4) begin
      errors++; $display("FAIL redirect: got pc=%h addr=%0d v=%b instr=%h cnt=%0d expected pc=84 addr=33 v=0 instr=13 cnt=4",
                         pc_o, imem_addr_o, ifid_valid_o, ifid_instr_o, fetch_cnt_o);
    end
    $display("redirect: pc=%h addr=%0d", pc_o, imem_addr_o);
    sb_q.push_back('{pc: 32'h84, instr: 32'h002083b3});
    tick();
    exp_f = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    checks++;
    if (ifid_valid_o !== 1'b1 || ifid_pc_o !== exp_f.pc || ifid_instr_o !== exp_f.instr || ifid_pc4_o !== 32'h88) begin
      errors++; $display("FAIL redirect_fetch: got pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=88",
                         ifid_pc_o, ifid_instr_o, ifid_pc4_o, exp_f.pc, exp_f.instr);
    end
    $display("fetch: ifid_pc=%h instr=%h", ifid_pc_o, ifid_instr_o);
  endtask

  task automatic test_pc_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFC;
    tick();
    redirect_i = 1'b0;
    checks++;
    if (imem_addr_o !== 6'd63) begin
      errors++; $display("FAIL wrap_addr63: got addr=%0d expected 63", imem_addr_o);
    end
    sb_q.push_back('{pc: 32'hFC, instr: mem[63]});
    tick();
    exp_f = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    checks++;
    if (ifid_pc_o !== exp_f.pc || ifid_instr_o !== exp_f.instr || pc_o !== 32'h100 || imem_addr_o !== 6'd0) begin
      errors++; $display("FAIL wrap_addr0: got ifid_pc=%h instr=%h pc=%h addr=%0d expected ifid_pc=%h instr=%h pc=100 addr=0",
                         ifid_pc_o, ifid_instr_o, pc_o, imem_addr_o, exp_f.pc, exp_f.instr);
    end
    $display("wrap: pc=%h addr=%0d", pc_o, imem_addr_o);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    sb_q.push_back('{pc: 32'hFFFF_FFFC, instr: mem[63]});
    tick();
    exp_f = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    checks++;
    if (ifid_pc_o !== exp_f.pc || ifid_instr_o !== exp_f.instr || ifid_pc4_o !== 32'h0 ||
        pc_o !== 32'h0 || fetch_cnt_o !== 32'd7) begin
      errors++; $display("FAIL pc_wrap32: got ifid_pc=%h pc4=%h pc=%h cnt=%0d expected ifid_pc=fffffffc pc4=0 pc=0 cnt=7",
                         ifid_pc_o, ifid_pc4_o, pc_o, fetch_cnt_o);
    end
    $display("wrap32: pc=%h ifid_pc4=%h", pc_o, ifid_pc4_o);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{pc: 32'(i * 4), instr: mem[i]});
      tick();
      exp_f = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
      checks++;
      if (ifid_valid_o !== 1'b1 || ifid_pc_o !== exp_f.pc || ifid_instr_o !== exp_f.instr ||
          fetch_cnt_o !== 32'(8 + i)) begin
        errors++; $display("FAIL b2b[%0d]: got pc=%h instr=%h cnt=%0d expected pc=%h instr=%h cnt=%0d",
                           i, ifid_pc_o, ifid_instr_o, fetch_cnt_o, exp_f.pc, exp_f.instr, 8 + i);
      end
      $display("b2b: ifid_pc=%h instr=%h cnt=%0d", ifid_pc_o, ifid_instr_o, fetch_cnt_o);
    end
  endtask

  task automatic test_halt();
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    checks++;
    if (halted_o !== 1'b1 || ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h13 ||
        pc_o !== 32'h10 || fetch_cnt_o !== 32'd11) begin
      errors++; $display("FAIL halt_enter: got halted=%b v=%b instr=%h pc=%h cnt=%0d expected halted=1 v=0 instr=13 pc=10 cnt=11",
                         halted_o, ifid_valid_o, ifid_instr_o, pc_o, fetch_cnt_o);
    end
    $display("halt: halted=%b pc=%h", halted_o, pc_o);
    redirect_i = 1'b1; redirect_pc_i = 32'h40; stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (halted_o !== 1'b1 || pc_o !== 32'h10 || ifid_valid_o !== 1'b0 || fetch_cnt_o !== 32'd11) begin
        errors++; $display("FAIL halt_absorb[%0d]: got halted=%b pc=%h v=%b cnt=%0d expected halted=1 pc=10 v=0 cnt=11",
                           i, halted_o, pc_o, ifid_valid_o, fetch_cnt_o);
      end
      $display("halted: pc=%h v=%b", pc_o, ifid_valid_o);
    end
    redirect_i = 1'b0; stall_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc_o !== 32'h8 || fetch_cnt_o !== 32'd0 || halted_o !== 1'b0) begin
      errors++; $display("FAIL async_reset: got pc=%h cnt=%0d halted=%b expected pc=8 cnt=0 halted=0",
                         pc_o, fetch_cnt_o, halted_o);
    end
    $display("async reset: pc=%h cnt=%0d", pc_o, fetch_cnt_o);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[2]  = 32'h0002a083;
    mem[3]  = 32'h0042a103;
    mem[33] = 32'h002083b3;
    test_reset();
    test_boot_fetch();
    test_stall();
    test_conflict();
    test_redirect();
    test_pc_wrap();
    test_back_to_back();
    test_halt();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
